// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_scoreboard_if                                       |
// | Description : D-stage decode view and hazard results exchanged between   |
// |               the decoder (master) and the hazard scoreboard (slave).    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface hazard_scoreboard_if #(
   parameter int NUM_STG = 3,
   parameter int ADDR_W  = 5,
   parameter int TNEW_W  = 2
) ();
   localparam int SEL_W = $clog2(NUM_STG + 1);

   // D-stage decode information
   logic              d_valid;
   logic [ADDR_W-1:0] d_rs;
   logic [ADDR_W-1:0] d_rt;
   logic [TNEW_W-1:0] d_tuse_rs;
   logic [TNEW_W-1:0] d_tuse_rt;
   logic              d_use_rs;
   logic              d_use_rt;
   logic              d_wr_en;
   logic [ADDR_W-1:0] d_wr_addr;
   logic [TNEW_W-1:0] d_tnew;
   logic              d_md_start;
   logic              d_md_div;
   logic              d_md_acc;

   // Hazard results back to the pipeline control
   logic              stall;
   logic [SEL_W-1:0]  fwd_rs_sel;
   logic [SEL_W-1:0]  fwd_rt_sel;
   logic              md_busy;
   logic [31:0]       stall_cnt;

   modport master (
      output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_use_rs, d_use_rt,
             d_wr_en, d_wr_addr, d_tnew, d_md_start, d_md_div, d_md_acc,
      input  stall, fwd_rs_sel, fwd_rt_sel, md_busy, stall_cnt
   );

   modport slave (
      input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_use_rs, d_use_rt,
             d_wr_en, d_wr_addr, d_tnew, d_md_start, d_md_div, d_md_acc,
      output stall, fwd_rs_sel, fwd_rt_sel, md_busy, stall_cnt
   );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_scoreboard                                          |
// | Description : Tuse/Tnew hazard unit. Tracks in-flight GPR writers past D |
// |               in a shadow pipeline plus a mult/div busy countdown and    |
// |               produces the D-stage stall and forward selects.            |
// |               Optional: HAZ_STATS_EN enables the 32-bit stall counter;   |
// |               without it stall_cnt is tied to zero.                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module hazard_scoreboard #(
   parameter int NUM_STG  = 3,
   parameter int ADDR_W   = 5,
   parameter int TNEW_W   = 2,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic               clk,
   input  logic               reset,
   hazard_scoreboard_if.slave hz
);
   localparam int SEL_W  = $clog2(NUM_STG + 1);
   localparam int MD_MAX = ((DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT) + 1;
   localparam int MD_W   = $clog2(MD_MAX + 1);
   localparam logic [MD_W-1:0] C_MD_LOAD_MULT = MD_W'(MULT_LAT + 1);
   localparam logic [MD_W-1:0] C_MD_LOAD_DIV  = MD_W'(DIV_LAT + 1);

   typedef struct packed {
      logic              hit;
      logic [SEL_W-1:0]  stg;
      logic [TNEW_W-1:0] tnew;
   } match_t;

   // Shadow pipeline: index k is the stage k cycles past D (1 = E)
   logic [NUM_STG:1]  vld_q;
   logic [NUM_STG:1]  vld_d;
   logic [ADDR_W-1:0] addr_q [1:NUM_STG];
   logic [ADDR_W-1:0] addr_d [1:NUM_STG];
   logic [TNEW_W-1:0] tnew_q [1:NUM_STG];
   logic [TNEW_W-1:0] tnew_d [1:NUM_STG];

   logic [MD_W-1:0]   md_cnt_q;
   logic [MD_W-1:0]   md_cnt_d;

   logic              md_busy;
   logic              stall;
   logic [SEL_W-1:0]  fwd_rs_sel;
   logic [SEL_W-1:0]  fwd_rt_sel;
   match_t            rs_m;
   match_t            rt_m;

   // Youngest valid record writing reg_a; $0 and unused operands never match
   function automatic match_t find_match(input logic use_en, input logic [ADDR_W-1:0] reg_a);
      match_t m;
      m = '0;
      if (use_en && (reg_a != '0)) begin
         // Walk oldest to youngest so the youngest hit overwrites older ones
         for (int k = NUM_STG; k >= 1; k--) begin
            if (vld_q[k] && (addr_q[k] == reg_a)) begin
               m.hit  = 1'b1;
               m.stg  = SEL_W'(k);
               m.tnew = tnew_q[k];
            end
         end
      end
      return m;
   endfunction

   assign md_busy = (md_cnt_q != '0);

   // Operand matching, stall decision and forward-source selection
   always_comb begin
      rs_m       = find_match(hz.d_use_rs, hz.d_rs);
      rt_m       = find_match(hz.d_use_rt, hz.d_rt);
      stall      = 1'b0;
      fwd_rs_sel = '0;
      fwd_rt_sel = '0;
      if (hz.d_valid) begin
         if (rs_m.hit && (rs_m.tnew > hz.d_tuse_rs)) begin
            stall = 1'b1;
         end
         if (rt_m.hit && (rt_m.tnew > hz.d_tuse_rt)) begin
            stall = 1'b1;
         end
         // Any HI/LO user, including a new mult/div, waits for the unit
         if ((hz.d_md_acc || hz.d_md_start) && md_busy) begin
            stall = 1'b1;
         end
         // Ready results come from their stage; not-yet-ready ones are
         // picked up downstream, so the D-stage select stays on the RF
         if (rs_m.hit && (rs_m.tnew == '0)) begin
            fwd_rs_sel = rs_m.stg;
         end
         if (rt_m.hit && (rt_m.tnew == '0)) begin
            fwd_rt_sel = rt_m.stg;
         end
      end
   end

   // Next shadow pipeline: new writer enters stage 1, older ones age by one
   always_comb begin
      vld_d     = '0;
      vld_d[1]  = hz.d_valid & hz.d_wr_en & (hz.d_wr_addr != '0) & ~stall;
      addr_d[1] = hz.d_wr_addr;
      tnew_d[1] = hz.d_tnew;
      for (int k = 2; k <= NUM_STG; k++) begin
         vld_d[k]  = vld_q[k-1];
         addr_d[k] = addr_q[k-1];
         tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : (tnew_q[k-1] - TNEW_W'(1));
      end
   end

   // Shadow pipeline registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         for (int k = 1; k <= NUM_STG; k++) begin
            addr_q[k] <= '0;
            tnew_q[k] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int k = 1; k <= NUM_STG; k++) begin
            addr_q[k] <= addr_d[k];
            tnew_q[k] <= tnew_d[k];
         end
      end
   end

   // Mult/div countdown: load latency+1 on an accepted issue, then drain
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (hz.d_valid && hz.d_md_start && !stall) begin
         md_cnt_d = hz.d_md_div ? C_MD_LOAD_DIV : C_MD_LOAD_MULT;
      end else if (md_busy) begin
         md_cnt_d = md_cnt_q - MD_W'(1);
      end
   end

   // Mult/div countdown register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_cnt_q <= '0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end

`ifdef HAZ_STATS_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;

   // Stall-cycle counter, wraps naturally at 2^32
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Stall-cycle counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
`else
   assign hz.stall_cnt = 32'h0;
`endif

   assign hz.stall      = stall;
   assign hz.fwd_rs_sel = fwd_rs_sel;
   assign hz.fwd_rt_sel = fwd_rt_sel;
   assign hz.md_busy    = md_busy;

endmodule
`default_nettype wire
